arty_tohost_monitor: RTL and testbench

Passive end-of-test detector for the Arty FPGA simulation harness. It snoops the memory write channel for stores to the `tohost` address and decodes the exit code. A watchdog catches stalled programs. It drives the harness `success` output that the test driver samples every cycle, plus a sticky failure status and code for the driver's failure report. It never back-pressures the bus.

---
 rtl/arty_tohost_monitor.sv | 111 +++++++++++
 tb/tb_arty_tohost_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arty_tohost_monitor.sv
// End-of-test detector: snoops write beats to tohost, decodes the exit code,
// and runs an idle watchdog. Never drives the bus; all outputs are registered.
module arty_tohost_monitor #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR     = 32'h8000_1000,
  parameter int unsigned           WATCHDOG_CYCLES = 1_000_000,
  parameter int                    WATCHDOG_WIDTH  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_valid,
  input  logic                      wr_ready,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [7:0]                wr_mask,
  input  logic                      progress,
  output logic                      success,
  output logic                      failure,
  output logic [62:0]               fail_code,
  output logic                      done,
  output logic [1:0]                o_dbg_state,
  output logic [WATCHDOG_WIDTH-1:0] o_dbg_wd
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam bit                        WD_EN   = (WATCHDOG_CYCLES != 0);
  localparam logic [WATCHDOG_WIDTH-1:0] WD_LAST =
    WATCHDOG_WIDTH'((WATCHDOG_CYCLES == 0) ? 0 : WATCHDOG_CYCLES - 1);
  localparam logic [62:0]               TIMEOUT_CODE = '1;

  state_t                    r_state;
  logic [WATCHDOG_WIDTH-1:0] r_wd;
  logic                      r_success;
  logic                      r_failure;
  logic [62:0]               r_fail_code;
  logic                      r_done;

  logic                      w_fire;
  logic                      w_hit;
  logic                      w_data_nz;
  logic                      w_clear;
  logic                      w_exit;
  logic [62:0]               w_code;
  logic                      w_expire;
  logic                      w_unused;

  // Handshake: a beat transfers only in a cycle with wr_valid && wr_ready both
  // high; address, data and mask are looked at only in that cycle. The monitor
  // is passive and never influences wr_ready.
  assign w_fire    = wr_valid && wr_ready;
  assign w_hit     = w_fire
                     && (wr_addr[ADDR_WIDTH-1:3] == TOHOST_ADDR[ADDR_WIDTH-1:3])
                     && (wr_mask[3:0] == 4'hF);
  assign w_data_nz = (wr_data != '0);
  assign w_exit    = w_hit && wr_data[0];
  assign w_code    = wr_data[63:1];
  assign w_clear   = progress || (w_hit && w_data_nz);
  assign w_expire  = WD_EN && (r_wd == WD_LAST) && !w_clear;

  // Byte lanes below the doubleword offset and the upper strobes never matter.
  assign w_unused  = ^{wr_addr[2:0], wr_mask[7:4]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_wd        <= '0;
      r_success   <= 1'b0;
      r_failure   <= 1'b0;
      r_fail_code <= '0;
      r_done      <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_clear) begin
        r_wd <= '0;
      end else if (r_wd != '1) begin
        r_wd <= r_wd + 1'b1;
      end

      // An exit in the expiry cycle wins over the timeout.
      if (w_exit) begin
        r_done <= 1'b1;
        if (w_code == '0) begin
          r_state   <= ST_PASS;
          r_success <= 1'b1;
        end else begin
          r_state     <= ST_FAIL;
          r_failure   <= 1'b1;
          r_fail_code <= w_code;
        end
      end else if (w_expire) begin
        r_state     <= ST_FAIL;
        r_failure   <= 1'b1;
        r_fail_code <= TIMEOUT_CODE;
        r_done      <= 1'b1;
      end
    end
  end

  assign success     = r_success;
  assign failure     = r_failure;
  assign fail_code   = r_fail_code;
  assign done        = r_done;
  assign o_dbg_state = r_state;
  assign o_dbg_wd    = r_wd;

endmodule

// File: tb/tb_arty_tohost_monitor.sv
// Directed and randomized checks of arty_tohost_monitor against an
// edge-stamped behavioural model (16-cycle watchdog).
module tb_arty_tohost_monitor;

  localparam int          WD     = 16;
  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam logic [62:0] ALL1   = '1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic        progress = 1'b0;
  logic        success;
  logic        failure;
  logic [62:0] fail_code;
  logic        done;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_wd;

  arty_tohost_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .TOHOST_ADDR(TOHOST),
    .WATCHDOG_CYCLES(WD), .WATCHDOG_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .progress(progress),
    .success(success), .failure(failure), .fail_code(fail_code), .done(done),
    .o_dbg_state(dbg_state), .o_dbg_wd(dbg_wd)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: 0 running, 1 passed, 2 failed; edges are stamped since reset release.
  int          m_state = 0;
  logic [62:0] m_code  = '0;
  int          m_edge  = 0;
  int          m_last_clear = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit          hit;
    logic [62:0] code;
    m_edge++;
    if (m_state != 0) return;
    hit  = wr_valid && wr_ready && (wr_addr[31:3] == TOHOST[31:3]) && (wr_mask[3:0] == 4'hF);
    code = wr_data[63:1];
    if (hit && wr_data[0]) begin
      if (code == '0) m_state = 1;
      else begin
        m_state = 2;
        m_code  = code;
      end
    end else if (progress || (hit && wr_data != 64'd0)) begin
      m_last_clear = m_edge;
    end else if (m_edge - m_last_clear == WD) begin
      m_state = 2;
      m_code  = ALL1;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".success"},   64'(success),   64'(m_state == 1));
    check({tag, ".failure"},   64'(failure),   64'(m_state == 2));
    check({tag, ".fail_code"}, 64'(fail_code), (m_state == 2) ? 64'(m_code) : 64'd0);
    check({tag, ".done"},      64'(done),      64'(m_state != 0));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    compare_model(tag);
  endtask

  task automatic idle_ticks(input int n, input string tag);
    wr_valid = 1'b0;
    wr_ready = 1'b0;
    progress = 1'b0;
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic beat(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m,
                      input logic v, input logic r, input string tag);
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    wr_valid = v;
    wr_ready = r;
    tick(tag);
    wr_valid = 1'b0;
    wr_ready = 1'b0;
  endtask

  // Asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_ready = 1'b0;
    progress = 1'b0;
    #1;
    check({tag, ".rst_success"},   64'(success),   64'd0);
    check({tag, ".rst_failure"},   64'(failure),   64'd0);
    check({tag, ".rst_fail_code"}, 64'(fail_code), 64'd0);
    check({tag, ".rst_done"},      64'(done),      64'd0);
    check({tag, ".rst_wd"},        64'(dbg_wd),    64'd0);
    @(posedge clock);
    #1;
    reset        = 1'b0;
    m_state      = 0;
    m_code       = '0;
    m_edge       = 0;
    m_last_clear = 0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL tb_timeout: simulation did not finish within its time budget");
    $fatal(1);
  end

  initial begin
    int post_done;
    int r;

    // Reset state, filtering, and proof that a zero-data hit does not feed the watchdog.
    do_reset("init");
    beat(TOHOST + 32'd8, 64'h1, 8'hFF, 1'b1, 1'b1, "filt_addr");
    check("filt_addr.done", 64'(done), 64'd0);
    beat(TOHOST, 64'h1, 8'hFF, 1'b1, 1'b0, "filt_ready");
    check("filt_ready.done", 64'(done), 64'd0);
    beat(TOHOST, 64'h1, 8'hF0, 1'b1, 1'b1, "filt_mask");
    check("filt_mask.done", 64'(done), 64'd0);
    beat(TOHOST, 64'h0, 8'hFF, 1'b1, 1'b1, "filt_zero");
    check("filt_zero.done", 64'(done), 64'd0);
    idle_ticks(11, "filt_idle");
    check("filt_idle.failure_e15", 64'(failure), 64'd0);
    idle_ticks(1, "filt_to");
    check("filt_to.failure_e16", 64'(failure), 64'd1);
    check("filt_to.code", 64'(fail_code), 64'(ALL1));

    // Pass.
    do_reset("pass");
    idle_ticks(10, "pass_wait");
    beat(TOHOST, 64'h1, 8'hFF, 1'b1, 1'b1, "pass_hit");
    check("pass.success", 64'(success), 64'd1);
    check("pass.done", 64'(done), 64'd1);
    check("pass.failure", 64'(failure), 64'd0);
    check("pass.code", 64'(fail_code), 64'd0);
    idle_ticks(100, "pass_hold");
    check("pass_hold.success", 64'(success), 64'd1);
    check("pass_hold.failure", 64'(failure), 64'd0);

    // Nonzero exit code, then a later pass write is ignored.
    do_reset("fcode");
    beat(TOHOST, 64'h7, 8'hFF, 1'b1, 1'b1, "fcode_hit");
    check("fcode.failure", 64'(failure), 64'd1);
    check("fcode.code", 64'(fail_code), 64'd3);
    beat(TOHOST, 64'h1, 8'hFF, 1'b1, 1'b1, "fcode_late");
    check("fcode_late.success", 64'(success), 64'd0);
    check("fcode_late.code", 64'(fail_code), 64'd3);

    // Plain timeout at edge 16.
    do_reset("wd");
    idle_ticks(15, "wd_idle");
    check("wd.failure_e15", 64'(failure), 64'd0);
    idle_ticks(1, "wd_exp");
    check("wd.failure_e16", 64'(failure), 64'd1);
    check("wd.code", 64'(fail_code), 64'(ALL1));

    // Progress at edge 15 moves the timeout to edge 31.
    do_reset("wdp");
    idle_ticks(14, "wdp_idle");
    progress = 1'b1;
    tick("wdp_pulse");
    progress = 1'b0;
    idle_ticks(15, "wdp_idle2");
    check("wdp.failure_e30", 64'(failure), 64'd0);
    idle_ticks(1, "wdp_exp");
    check("wdp.failure_e31", 64'(failure), 64'd1);

    // Syscall at edge 10 moves the timeout to edge 26.
    do_reset("wds");
    idle_ticks(9, "wds_idle");
    beat(TOHOST, 64'h2, 8'hFF, 1'b1, 1'b1, "wds_sys");
    check("wds.done_e10", 64'(done), 64'd0);
    idle_ticks(15, "wds_idle2");
    check("wds.failure_e25", 64'(failure), 64'd0);
    idle_ticks(1, "wds_exp");
    check("wds.failure_e26", 64'(failure), 64'd1);

    // Exit in the expiry cycle wins.
    do_reset("race");
    idle_ticks(15, "race_idle");
    beat(TOHOST, 64'h1, 8'hFF, 1'b1, 1'b1, "race_hit");
    check("race.success", 64'(success), 64'd1);
    check("race.failure", 64'(failure), 64'd0);

    // Reset from FAIL mid-cycle, then pass.
    do_reset("mid_pre");
    beat(TOHOST, 64'h5, 8'hFF, 1'b1, 1'b1, "mid_fail");
    check("mid.failure", 64'(failure), 64'd1);
    do_reset("midreset");
    beat(TOHOST, 64'h1, 8'hFF, 1'b1, 1'b1, "mid_pass");
    check("mid_pass.success", 64'(success), 64'd1);

    // Random traffic against the model.
    do_reset("rnd");
    post_done = 0;
    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 5);
      if (r <= 2)      wr_addr = TOHOST + 32'($urandom_range(0, 7));
      else if (r == 3) wr_addr = TOHOST + 32'd8;
      else if (r == 4) wr_addr = TOHOST - 32'd8;
      else             wr_addr = $urandom;
      wr_mask = ($urandom_range(0, 3) != 0) ? {4'($urandom), 4'hF} : 8'($urandom);
      r = $urandom_range(0, 29);
      if (r <= 5)       wr_data = 64'd0;
      else if (r <= 25) wr_data = {$urandom, $urandom} & ~64'd1;
      else if (r <= 27) wr_data = 64'd1;
      else if (r == 28) wr_data = {31'($urandom), $urandom, 1'b1};
      else              wr_data = '1;
      progress = ($urandom_range(0, 9) == 0);
      tick("rnd");
      if (m_state != 0) post_done++;
      if (post_done > 8) begin
        do_reset("rnd_rst");
        post_done = 0;
      end
    end
    wr_valid = 1'b0;
    wr_ready = 1'b0;
    progress = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
